// File: rtl/dmem_pkg.sv
// Shared types and defaults for the wait-state data memory responder.
package dmem_pkg;

    localparam int unsigned DepthDefault      = 128;
    localparam int unsigned WaitCyclesDefault = 2;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

endpackage

// File: rtl/dmem_array.sv
// Word storage: one synchronous write port, two combinational read ports.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH = DepthDefault,
    parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] raddr_a_i,
    output logic [31:0]   rdata_a_o,
    input  logic [AW-1:0] raddr_b_i,
    output logic [31:0]   rdata_b_o
);

    // Power-up contents are zero; there is deliberately no reset clear.
    logic [31:0] mem_q [DEPTH] = '{default: 32'h0};

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = mem_q[raddr_a_i];
    assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding memory responder with fixed wait states and a debug read port.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = WaitCyclesDefault,
    parameter int unsigned DEPTH       = DepthDefault
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    input  logic [7:0]  dbg_addr,
    output logic [31:0] dbg_rdata
);

    localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  WaitLoad = 4'(WAIT_CYCLES);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        enter_resp;
    logic        txn_we;
    logic        txn_err;
    logic        mem_we;
    logic [31:0] txn_addr;
    logic [31:0] txn_wdata;
    logic [31:0] mem_rdata;
    logic [31:0] dbg_word;
    logic [31:0] dbg_mem;

    // In IDLE the live inputs stand in for the latches so a zero-wait access
    // can complete on its own accepting edge.
    assign txn_we    = (state_q == StIdle) ? req_we    : we_q;
    assign txn_addr  = (state_q == StIdle) ? req_addr  : addr_q;
    assign txn_wdata = (state_q == StIdle) ? req_wdata : wdata_q;
    assign txn_err   = (txn_addr[1:0] != 2'b00) || (32'(txn_addr[31:2]) >= DEPTH);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        enter_resp = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = WaitLoad;
                    if (WAIT_CYCLES == 0) begin
                        enter_resp = 1'b1;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    enter_resp = 1'b1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase

        if (enter_resp) begin
            state_d = StResp;
            rdata_d = (txn_err || txn_we) ? 32'h0 : mem_rdata;
            err_d   = txn_err;
        end
    end

    // Reset on the commit edge wins, so the write is gated here as well.
    assign mem_we = enter_resp && txn_we && !txn_err && reset;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign dbg_word = {26'd0, dbg_addr[7:2]};

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk       (clk),
        .we_i      (mem_we),
        .waddr_i   (AW'(txn_addr[31:2])),
        .wdata_i   (txn_wdata),
        .raddr_a_i (AW'(txn_addr[31:2])),
        .rdata_a_o (mem_rdata),
        .raddr_b_i (AW'(dbg_word)),
        .rdata_b_o (dbg_mem)
    );

    assign dbg_rdata = (dbg_word < DEPTH) ? dbg_mem : 32'h0;

    assign req_ready = (state_q == StIdle);
    assign rsp_valid = (state_q == StResp);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench: two responders (2 and 0 wait states) against a word-level memory model.
module tb_dmem_responder;

    logic        clk;
    logic        rst   [2];
    logic        rv    [2];
    logic        rq    [2];
    logic        we    [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic        vv    [2];
    logic        rr    [2];
    logic [31:0] rd    [2];
    logic        er    [2];
    logic [7:0]  dbg   [2];
    logic [31:0] dr    [2];

    logic [31:0] mdl [2][128];
    int n_checks;
    int n_errors;

    dmem_responder #(
        .WAIT_CYCLES (2),
        .DEPTH       (128)
    ) u_dut_w2 (
        .clk       (clk),
        .reset     (rst[0]),
        .req_valid (rv[0]),
        .req_ready (rq[0]),
        .req_we    (we[0]),
        .req_addr  (addr[0]),
        .req_wdata (wdata[0]),
        .rsp_valid (vv[0]),
        .rsp_ready (rr[0]),
        .rsp_rdata (rd[0]),
        .rsp_err   (er[0]),
        .dbg_addr  (dbg[0]),
        .dbg_rdata (dr[0])
    );

    dmem_responder #(
        .WAIT_CYCLES (0),
        .DEPTH       (128)
    ) u_dut_w0 (
        .clk       (clk),
        .reset     (rst[1]),
        .req_valid (rv[1]),
        .req_ready (rq[1]),
        .req_we    (we[1]),
        .req_addr  (addr[1]),
        .req_wdata (wdata[1]),
        .rsp_valid (vv[1]),
        .rsp_ready (rr[1]),
        .rsp_rdata (rd[1]),
        .rsp_err   (er[1]),
        .dbg_addr  (dbg[1]),
        .dbg_rdata (dr[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int wait_of(input int k);
        return (k == 0) ? 2 : 0;
    endfunction

    function automatic logic addr_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[31:2] >= 30'd128);
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        case ($urandom_range(0, 4))
            0, 1:    a = {23'd0, 7'($urandom_range(0, 15)), 2'b00};
            2:       a = {23'd0, 7'($urandom_range(0, 127)), 2'b00};
            3:       a = {23'd0, 7'($urandom_range(0, 127)), 2'($urandom_range(1, 3))};
            default: a = {20'd0, 10'($urandom_range(128, 1023)), 2'b00};
        endcase
        return a;
    endfunction

    task automatic check_idle_outputs(input int k, input string tag);
        check_val({tag, "_req_ready"}, 32'(rq[k]), 32'd1);
        check_val({tag, "_rsp_valid"}, 32'(vv[k]), 32'd0);
        check_val({tag, "_rsp_rdata"}, rd[k], 32'd0);
        check_val({tag, "_rsp_err"}, 32'(er[k]), 32'd0);
    endtask

    // One full transaction; inputs are scrambled after acceptance and the
    // response is held for `hold` cycles before the handshake.
    task automatic do_txn(input int k, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input int hold);
        logic        exp_err;
        logic [31:0] exp_rd;
        int          lat;
        exp_err = addr_bad(a);
        exp_rd  = (exp_err || w) ? 32'h0 : mdl[k][int'(a[8:2])];

        @(negedge clk);
        check_val("req_ready_before", 32'(rq[k]), 32'd1);
        rv[k] = 1'b1; we[k] = w; addr[k] = a; wdata[k] = d; rr[k] = 1'b0;
        @(negedge clk);
        if (w && !exp_err) mdl[k][int'(a[8:2])] = d;
        rv[k] = 1'($urandom_range(0, 1));
        we[k] = 1'($urandom_range(0, 1));
        addr[k] = $urandom;
        wdata[k] = $urandom;
        lat = 1;
        while (!vv[k] && lat < 40) begin
            check_val("req_ready_wait", 32'(rq[k]), 32'd0);
            rr[k] = 1'($urandom_range(0, 1));
            addr[k] = $urandom;
            wdata[k] = $urandom;
            @(negedge clk);
            lat++;
        end
        rr[k] = 1'b0;
        check_val("latency", 32'(lat), 32'(wait_of(k) + 1));
        check_val("rsp_err", 32'(er[k]), 32'(exp_err));
        check_val("rsp_rdata", rd[k], exp_rd);
        if (w && !exp_err && a[31:8] == 24'd0) begin
            dbg[k] = a[7:0];
            #1;
            check_val("dbg_after_commit", dr[k], d);
        end
        for (int i = 0; i < hold; i++) begin
            rv[k] = 1'($urandom_range(0, 1));
            addr[k] = $urandom;
            @(negedge clk);
            check_val("hold_valid", 32'(vv[k]), 32'd1);
            check_val("hold_rdata", rd[k], exp_rd);
            check_val("hold_err", 32'(er[k]), 32'(exp_err));
            check_val("hold_req_ready", 32'(rq[k]), 32'd0);
        end
        rr[k] = 1'b1;
        @(negedge clk);
        check_idle_outputs(k, "after_handshake");
        rv[k] = 1'b0;
        rr[k] = 1'b0;
    endtask

    initial begin
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic        e;
        logic [31:0] x;
        n_checks = 0;
        n_errors = 0;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 128; i++) mdl[k][i] = 32'h0;
            rst[k] = 1'b0; rv[k] = 1'b0; we[k] = 1'b0; addr[k] = '0;
            wdata[k] = '0; rr[k] = 1'b0; dbg[k] = '0;
        end
        repeat (3) @(negedge clk);
        check_idle_outputs(0, "reset_w2");
        check_idle_outputs(1, "reset_w0");
        rst[0] = 1'b1;
        rst[1] = 1'b1;

        // Reset one cycle after acceptance abandons the write.
        @(negedge clk);
        rv[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h20; wdata[0] = 32'h12345678;
        @(negedge clk);
        rv[0] = 1'b0; rst[0] = 1'b0;
        @(negedge clk);
        check_idle_outputs(0, "reset_mid_wait");
        rst[0] = 1'b1;
        do_txn(0, 1'b0, 32'h20, 32'h0, 0);

        // Reset on the edge that would enter RESP also blocks the commit.
        @(negedge clk);
        rv[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h24; wdata[0] = 32'hCAFEF00D;
        @(negedge clk);
        rv[0] = 1'b0;
        @(negedge clk);
        rst[0] = 1'b0;
        @(negedge clk);
        check_idle_outputs(0, "reset_resp_edge");
        rst[0] = 1'b1;
        dbg[0] = 8'h24;
        #1;
        check_val("dbg_no_commit", dr[0], 32'h0);

        do_txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 0);
        do_txn(0, 1'b0, 32'h10, 32'h0, 0);
        dbg[0] = 8'h10;
        #1;
        check_val("dbg_deadbeef", dr[0], 32'hDEADBEEF);

        do_txn(0, 1'b1, 32'h13, 32'hFFFFFFFF, 0);
        dbg[0] = 8'h10;
        #1;
        check_val("dbg_word4_unchanged", dr[0], 32'hDEADBEEF);
        do_txn(0, 1'b0, 32'h200, 32'h0, 0);
        do_txn(0, 1'b0, 32'h10, 32'h0, 5);

        for (int n = 0; n < 40; n++) begin
            do_txn(0, 1'($urandom_range(0, 1)), rand_addr(), $urandom, int'($urandom_range(0, 3)));
        end
        for (int n = 0; n < 30; n++) begin
            do_txn(1, 1'($urandom_range(0, 1)), rand_addr(), $urandom, int'($urandom_range(0, 3)));
        end

        // Zero wait states with both valid and ready held: one access every two cycles.
        rr[1] = 1'b1;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            check_val("b2b_req_ready", 32'(rq[1]), 32'd1);
            check_val("b2b_idle_valid", 32'(vv[1]), 32'd0);
            w = 1'($urandom_range(0, 1));
            a = rand_addr();
            d = $urandom;
            e = addr_bad(a);
            x = (e || w) ? 32'h0 : mdl[1][int'(a[8:2])];
            if (w && !e) mdl[1][int'(a[8:2])] = d;
            rv[1] = 1'b1; we[1] = w; addr[1] = a; wdata[1] = d;
            @(negedge clk);
            check_val("b2b_rsp_valid", 32'(vv[1]), 32'd1);
            check_val("b2b_busy", 32'(rq[1]), 32'd0);
            check_val("b2b_rdata", rd[1], x);
            check_val("b2b_err", 32'(er[1]), 32'(e));
            addr[1] = $urandom;
            wdata[1] = $urandom;
        end
        @(negedge clk);
        check_val("b2b_end_idle", 32'(rq[1]), 32'd1);
        rv[1] = 1'b0;
        rr[1] = 1'b0;

        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 64; i++) begin
                dbg[k] = {6'(i), 2'($urandom_range(0, 3))};
                #1;
                check_val("dbg_sweep", dr[k], mdl[k][i]);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter: WAIT_CYCLES, default 2, number of wait-state cycles between request acceptance and response (legal range 0..15).
REQ-002 Parameter: DEPTH, default 128, number of 32-bit words of storage.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 req_valid  input  1  initiator presents a request.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_we  input  1  1 = write, 0 = read.
REQ-008 req_addr  input  32  byte address; word-aligned accesses only.
REQ-009 req_wdata  input  32  write data.
REQ-010 rsp_valid  output  1  response available.
REQ-011 rsp_ready  input  1  initiator consumes the response.
REQ-012 rsp_rdata  output  32  read data; 0 for writes and errors.
REQ-013 rsp_err  output  1  access was misaligned or out of range.
REQ-014 dbg_addr  input  8  debug byte address for switch readback.
REQ-015 dbg_rdata  output  32  combinational read of word dbg_addr[7:2].

Function
REQ-016 FSM states are IDLE, WAIT and RESP; req_ready is 1 only in IDLE, and rsp_valid is 1 only in RESP.
REQ-017 A request is accepted on a rising edge where req_valid and req_ready are both 1; at that edge req_we, req_addr and req_wdata are latched, and later changes on these inputs are ignored.
REQ-018 On acceptance, the wait counter loads WAIT_CYCLES and the FSM enters WAIT, or enters RESP directly when WAIT_CYCLES = 0.
REQ-019 In WAIT the counter decrements once per cycle, and the FSM enters RESP on the edge where the counter equals 1.
REQ-020 Latency: rsp_valid rises exactly WAIT_CYCLES+1 cycles after the accepting edge.
REQ-021 Error condition: latched addr[1:0] != 0, or latched addr[31:2] >= DEPTH.
REQ-022 On the edge that enters RESP:
  - Write, no error: the write commits to word addr[31:2].
  - Read, no error: rsp_rdata registers the stored word.
  - Error: no write occurs, rsp_rdata = 0 and rsp_err = 1.
REQ-023 In RESP, rsp_valid, rsp_rdata and rsp_err hold stable until an edge with rsp_ready = 1, after which the FSM returns to IDLE and rsp_valid, rsp_rdata and rsp_err clear to 0.
REQ-024 req_ready is 0 in RESP, so a new request is never accepted in the response-handshake cycle; peak throughput is one transaction per WAIT_CYCLES+2 cycles.
REQ-025 rsp_ready asserted outside RESP has no effect.
REQ-026 dbg_rdata = word dbg_addr[7:2] combinationally, and reflects a committed write from the cycle after the commit.
REQ-027 Storage powers up all-zero and has no reset clear.

Reset
REQ-028 When reset = 0 at a rising edge:
  - FSM goes to IDLE and the counter clears.
  - req_ready = 1; rsp_valid, rsp_rdata and rsp_err = 0.
REQ-029 Reset during WAIT abandons the transaction, and no write commits.
REQ-030 Reset asserted on the edge that would enter RESP takes priority, and the write does not commit.
REQ-031 Storage contents are unchanged by reset.

Structure
REQ-032 Shared package dmem_pkg holds the FSM state enum, the DEPTH default and the WAIT_CYCLES default.
REQ-033 A single sub-module, dmem_array, provides 1 synchronous write port and 2 combinational read ports (transaction and debug); the FSM, counter and response registers reside in dmem_responder.

Verification
REQ-034 Write then read, with WAIT_CYCLES = 2 and rsp_ready held at 1:
  - Write 0xDEADBEEF to address 0x10 -> rsp_valid 3 cycles after acceptance with rsp_err = 0.
  - Read 0x10 -> rsp_rdata = 0xDEADBEEF.
  - dbg_addr = 0x10 -> dbg_rdata = 0xDEADBEEF.
REQ-035 Backpressure: read with rsp_ready low for 5 cycles -> rsp_valid, rsp_rdata and rsp_err stable throughout, req_ready = 0, and a second req_valid is not accepted until the cycle after the response handshake.
REQ-036 Errors:
  - Write to address 0x13 -> rsp_err = 1 and word 4 unchanged.
  - Read from address 0x200 (DEPTH = 128) -> rsp_err = 1 and rsp_rdata = 0.
REQ-037 WAIT_CYCLES = 0: back-to-back requests -> each rsp_valid occurs 1 cycle after acceptance, and throughput is one transaction per 2 cycles.
REQ-038 Reset mid-WAIT: write 0x12345678 to 0x20, then reset = 0 one cycle after acceptance -> outputs zero, req_ready = 1, and a subsequent read of 0x20 returns the prior value (0).
REQ-039 Input stability: change req_addr and req_wdata during WAIT -> the latched values are used and the changes are ignored.
